// File: rtl/div_bcd.sv
// Sequential BCD long divider: 8-digit dividend / 4-digit divisor, one subtract per cycle.
// Optional non-BCD input detection is compiled in with DIV_BCD_CHECK_EN.
module div_bcd #(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        ready,
    output logic        done,
    output logic        valid,
    output logic [31:0] quotient,
    output logic [15:0] remainder,
    output logic        dz,
    output logic        err
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StShift = 3'd1;
    localparam logic [2:0] StSub   = 3'd2;
    localparam logic [2:0] StConv  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] a_buf_q, a_buf_d;
    logic [13:0] d_q, d_d;
    logic [16:0] r_q, r_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] q_buf_q, q_buf_d;
    logic [1:0]  place_q, place_d;
    logic [11:0] rdig_q, rdig_d;
    logic [31:0] quotient_q, quotient_d;
    logic [15:0] remainder_q, remainder_d;
    logic        dz_q, dz_d;
    logic        valid_q, valid_d;
    logic        err_d;
    logic [3:0]  cur_digit;
    logic [13:0] place_val;
    logic [13:0] divisor_bin;
    logic        bad_digit;

    function automatic logic [13:0] bcd4_to_bin(input logic [15:0] b);
        return 14'(b[15:12]) * 14'd1000 + 14'(b[11:8]) * 14'd100
             + 14'(b[7:4]) * 14'd10 + 14'(b[3:0]);
    endfunction

`ifdef DIV_BCD_CHECK_EN
    function automatic logic has_non_bcd(input logic [47:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    logic err_q;
    assign bad_digit = has_non_bcd({dividend, divisor});
    assign err       = err_q;
`else
    assign bad_digit = 1'b0;
    assign err       = 1'b0;
`endif

    assign divisor_bin = bcd4_to_bin(divisor);
    assign cur_digit   = a_buf_q[idx_q*DIGIT_W +: DIGIT_W];

    always_comb begin
        place_val = 14'd10;
        case (place_q)
            2'd0:    place_val = 14'd1000;
            2'd1:    place_val = 14'd100;
            default: place_val = 14'd10;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_buf_d     = a_buf_q;
        d_d         = d_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        q_buf_d     = q_buf_q;
        place_d     = place_q;
        rdig_d      = rdig_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        valid_d     = valid_q;
        err_d       = 1'b0;
`ifdef DIV_BCD_CHECK_EN
        err_d       = err_q;
`endif

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_buf_d = dividend;
                    d_d     = divisor_bin;
                    idx_d   = 3'd7;
                    cnt_d   = 4'd0;
                    q_buf_d = 32'd0;
                    valid_d = 1'b0;
                    // R starts at zero, so the first shift reduces to loading a7.
                    r_d     = {13'd0, dividend[31:28]};
                    if (bad_digit || divisor_bin == 14'd0) begin
                        quotient_d  = 32'd0;
                        remainder_d = 16'd0;
                        err_d       = bad_digit;
                        dz_d        = !bad_digit;
                        valid_d     = 1'b1;
                        state_d     = StDone;
                    end else begin
                        state_d = StSub;
                    end
                end
            end
            StShift: begin
                r_d     = r_q * 17'd10 + {13'd0, cur_digit};
                cnt_d   = 4'd0;
                state_d = StSub;
            end
            StSub: begin
                if (r_q >= {3'd0, d_q}) begin
                    r_d   = r_q - {3'd0, d_q};
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    q_buf_d[idx_q*DIGIT_W +: DIGIT_W] = cnt_q;
                    if (idx_q == 3'd0) begin
                        place_d = 2'd0;
                        rdig_d  = 12'd0;
                        state_d = StConv;
                    end else begin
                        idx_d   = idx_q - 3'd1;
                        state_d = StShift;
                    end
                end
            end
            StConv: begin
                if (r_q >= {3'd0, place_val}) begin
                    r_d = r_q - {3'd0, place_val};
                    case (place_q)
                        2'd0:    rdig_d[11:8] = rdig_q[11:8] + 4'd1;
                        2'd1:    rdig_d[7:4]  = rdig_q[7:4] + 4'd1;
                        default: rdig_d[3:0]  = rdig_q[3:0] + 4'd1;
                    endcase
                end else if (place_q == 2'd2) begin
                    quotient_d  = q_buf_q;
                    remainder_d = {rdig_q, r_q[3:0]};
                    dz_d        = 1'b0;
                    err_d       = 1'b0;
                    valid_d     = 1'b1;
                    state_d     = StDone;
                end else begin
                    place_d = place_q + 2'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= 3'd0;
            a_buf_q     <= 32'd0;
            d_q         <= 14'd0;
            r_q         <= 17'd0;
            cnt_q       <= 4'd0;
            q_buf_q     <= 32'd0;
            place_q     <= 2'd0;
            rdig_q      <= 12'd0;
            quotient_q  <= 32'd0;
            remainder_q <= 16'd0;
            dz_q        <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_buf_q     <= a_buf_d;
            d_q         <= d_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            q_buf_q     <= q_buf_d;
            place_q     <= place_d;
            rdig_q      <= rdig_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
            valid_q     <= valid_d;
        end
    end

`ifdef DIV_BCD_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_d;
`endif

    assign ready     = (state_q == StIdle);
    assign done      = (state_q == StDone);
    assign valid     = valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_div_bcd.sv
// Directed bench for div_bcd: results, latency, handshake, reset and BCD-check behaviour.
module tb_div_bcd;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        ready;
    logic        done;
    logic        valid;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        dz;
    logic        err;

    int compared;
    int mismatched;

    div_bcd #(.DIGIT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge of the done cycle (lat = 200 on timeout).
    task automatic do_op(input logic [31:0] a, input logic [15:0] b, output int lat);
        int guard;
        guard = 0;
        while (!ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'h0;
        divisor  = 16'h0;
        while (!done && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        compared++;
        if (ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b want 1", ready); end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
        compared++;
        if (valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", valid); end
        compared++;
        if (quotient !== 32'h0) begin
            mismatched++; $display("FAIL reset_quotient got %h want 00000000", quotient);
        end
        compared++;
        if (remainder !== 16'h0) begin
            mismatched++; $display("FAIL reset_remainder got %h want 0000", remainder);
        end
        compared++;
        if (dz !== 1'b0 || err !== 1'b0) begin
            mismatched++; $display("FAIL reset_flags got dz=%b err=%b want 0 0", dz, err);
        end
    endtask

    task automatic test_basic();
        int lat;
        do_op(32'h12345678, 16'h5678, lat);
        compared++;
        if (quotient !== 32'h00002174) begin
            mismatched++; $display("FAIL basic_quotient got %h want 00002174", quotient);
        end
        compared++;
        if (remainder !== 16'h1706) begin
            mismatched++; $display("FAIL basic_remainder got %h want 1706", remainder);
        end
        compared++;
        if (lat !== 41) begin mismatched++; $display("FAIL basic_latency got %0d want 41", lat); end
        compared++;
        if (valid !== 1'b1 || dz !== 1'b0 || ready !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_status got valid=%b dz=%b ready=%b want 1 0 0", valid, dz, ready);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || ready !== 1'b1 || valid !== 1'b1 || quotient !== 32'h00002174) begin
            mismatched++;
            $display("FAIL basic_hold got done=%b ready=%b valid=%b q=%h want 0 1 1 00002174",
                     done, ready, valid, quotient);
        end
    endtask

    task automatic test_inverse();
        int lat;
        do_op(32'h07006652, 16'h5678, lat);
        compared++;
        if (quotient !== 32'h00001234 || remainder !== 16'h0000) begin
            mismatched++;
            $display("FAIL inverse_result got %h r %h want 00001234 r 0000", quotient, remainder);
        end
        compared++;
        if (lat !== 29) begin mismatched++; $display("FAIL inverse_latency got %0d want 29", lat); end
    endtask

    task automatic test_boundary();
        int lat;
        do_op(32'h99999999, 16'h9999, lat);
        compared++;
        if (quotient !== 32'h00010001 || remainder !== 16'h0000) begin
            mismatched++;
            $display("FAIL max_result got %h r %h want 00010001 r 0000", quotient, remainder);
        end
        compared++;
        if (lat !== 21) begin mismatched++; $display("FAIL max_latency got %0d want 21", lat); end
        do_op(32'h00000009, 16'h9999, lat);
        compared++;
        if (quotient !== 32'h0 || remainder !== 16'h0009) begin
            mismatched++;
            $display("FAIL small_result got %h r %h want 00000000 r 0009", quotient, remainder);
        end
        compared++;
        if (lat !== 19) begin mismatched++; $display("FAIL small_latency got %0d want 19", lat); end
    endtask

    task automatic test_zero_div();
        int lat;
        do_op(32'h12345678, 16'h0000, lat);
        compared++;
        if (dz !== 1'b1 || err !== 1'b0) begin
            mismatched++; $display("FAIL dz_flag got dz=%b err=%b want 1 0", dz, err);
        end
        compared++;
        if (quotient !== 32'h0 || remainder !== 16'h0 || valid !== 1'b1) begin
            mismatched++;
            $display("FAIL dz_result got %h r %h valid=%b want 0 r 0 valid=1",
                     quotient, remainder, valid);
        end
        compared++;
        if (lat !== 1) begin mismatched++; $display("FAIL dz_latency got %0d want 1", lat); end
        do_op(32'h00000010, 16'h0002, lat);
        compared++;
        if (quotient !== 32'h00000005 || remainder !== 16'h0 || dz !== 1'b0) begin
            mismatched++;
            $display("FAIL after_dz got %h r %h dz=%b want 00000005 r 0000 dz=0",
                     quotient, remainder, dz);
        end
        compared++;
        if (lat !== 24) begin mismatched++; $display("FAIL after_dz_latency got %0d want 24", lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(32'h00000010, 16'h0002, lat);
        compared++;
        if (ready !== 1'b0) begin mismatched++; $display("FAIL b2b_ready_in_done got %b want 0", ready); end
        // Second op must be accepted at the edge leaving the first IDLE cycle.
        do_op(32'h07006652, 16'h1234, lat);
        compared++;
        if (quotient !== 32'h00005678 || remainder !== 16'h0) begin
            mismatched++;
            $display("FAIL b2b_result got %h r %h want 00005678 r 0000", quotient, remainder);
        end
        compared++;
        if (lat !== 45) begin mismatched++; $display("FAIL b2b_latency got %0d want 45", lat); end
    endtask

    task automatic test_start_held();
        int lat;
        int dones;
        dividend = 32'h12345678;
        divisor  = 16'h5678;
        start    = 1'b1;
        @(posedge clk);
        lat   = 1;
        dones = 0;
        @(negedge clk);
        while (!done && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        compared++;
        if (lat !== 41) begin mismatched++; $display("FAIL held_latency got %0d want 41", lat); end
        compared++;
        if (dones !== 1) begin mismatched++; $display("FAIL held_done_count got %0d want 1", dones); end
        compared++;
        if (quotient !== 32'h00002174 || ready !== 1'b1) begin
            mismatched++;
            $display("FAIL held_result got %h ready=%b want 00002174 ready=1", quotient, ready);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        dividend = 32'h12345678;
        divisor  = 16'h5678;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (ready !== 1'b1 || done !== 1'b0 || valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_status got ready=%b done=%b valid=%b want 1 0 0",
                     ready, done, valid);
        end
        compared++;
        if (quotient !== 32'h0 || remainder !== 16'h0 || dz !== 1'b0 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_outputs got %h r %h dz=%b err=%b want all zero",
                     quotient, remainder, dz, err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        compared++;
        if (dones !== 0 || ready !== 1'b1 || valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_after got dones=%0d ready=%b valid=%b want 0 1 0",
                     dones, ready, valid);
        end
    endtask

    task automatic test_bcd_err();
        int lat;
        do_op(32'h0000000A, 16'h0001, lat);
`ifdef DIV_BCD_CHECK_EN
        compared++;
        if (err !== 1'b1 || dz !== 1'b0) begin
            mismatched++; $display("FAIL err_flag got err=%b dz=%b want 1 0", err, dz);
        end
        compared++;
        if (quotient !== 32'h0 || remainder !== 16'h0) begin
            mismatched++;
            $display("FAIL err_result got %h r %h want 0 r 0", quotient, remainder);
        end
        compared++;
        if (lat !== 1) begin mismatched++; $display("FAIL err_latency got %0d want 1", lat); end
`else
        compared++;
        if (err !== 1'b0 || dz !== 1'b0) begin
            mismatched++; $display("FAIL noerr_flag got err=%b dz=%b want 0 0", err, dz);
        end
        compared++;
        if (quotient !== 32'h0000000A || remainder !== 16'h0) begin
            mismatched++;
            $display("FAIL noerr_result got %h r %h want 0000000a r 0000", quotient, remainder);
        end
        compared++;
        if (lat !== 29) begin mismatched++; $display("FAIL noerr_latency got %0d want 29", lat); end
`endif
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        dividend   = 32'h0;
        divisor    = 16'h0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_inverse();
        test_boundary();
        test_zero_div();
        test_back_to_back();
        @(negedge clk);
        test_start_held();
        test_reset_mid();
        test_bcd_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
